// File: rtl/mem_arbiter.sv
// Serializes icache fills, dcache fills and dcache writebacks onto one memory line port.
// Writebacks win; competing reads alternate; each completion is answered by a one-cycle pulse.
module mem_arbiter #(
  parameter int ARCH_BITS        = 32,
  parameter int MEMORY_LINE_BITS = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iReadMemReq,
  input  logic [ARCH_BITS-1:0]        iReadMemAddr,
  output logic [MEMORY_LINE_BITS-1:0] iReadMemData,
  output logic                        iReadMemLineValid,
  input  logic                        dReadMemReq,
  input  logic [ARCH_BITS-1:0]        dReadMemAddr,
  output logic [MEMORY_LINE_BITS-1:0] dReadMemData,
  output logic                        dReadMemLineValid,
  input  logic                        dWriteMemReq,
  input  logic [ARCH_BITS-1:0]        dWriteMemAddr,
  input  logic [MEMORY_LINE_BITS-1:0] dWriteMemLine,
  output logic                        dWriteMemAck,
  output logic                        memReq,
  output logic                        memWE,
  output logic [ARCH_BITS-1:0]        memAddr,
  output logic [MEMORY_LINE_BITS-1:0] memWData,
  input  logic                        memAck,
  input  logic [MEMORY_LINE_BITS-1:0] memRData
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DWR  = 3'd1,
    DRD  = 3'd2,
    IRD  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  state_t                        r_owner;
  logic                          r_last_grant_d;
  logic                          r_mem_req;
  logic                          r_mem_we;
  logic [ARCH_BITS-1:0]          r_mem_addr;
  logic [MEMORY_LINE_BITS-1:0]   r_mem_wdata;
  logic [MEMORY_LINE_BITS-1:0]   r_i_data;
  logic [MEMORY_LINE_BITS-1:0]   r_d_data;
  logic [ARCH_BITS-1:0]          w_grant_addr;
  logic                          w_grant;
  logic                          w_busy;
  logic                          w_i_pulse;
  logic                          w_d_pulse;
  logic                          w_wr_ack;

  assign w_grant = (r_state == IDLE) && (w_state_nxt != IDLE);
  assign w_busy  = (r_state == DWR) || (r_state == DRD) || (r_state == IRD);

  // Next-state selection: grant priority in IDLE, wait for memAck, single RESP cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (dWriteMemReq) begin
          w_state_nxt = DWR;
        end else if (dReadMemReq && iReadMemReq) begin
          w_state_nxt = r_last_grant_d ? IRD : DRD;
        end else if (dReadMemReq) begin
          w_state_nxt = DRD;
        end else if (iReadMemReq) begin
          w_state_nxt = IRD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DWR, DRD, IRD: begin
        if (memAck) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address of the requester being granted this cycle
  always_comb begin
    w_grant_addr = r_mem_addr;
    case (w_state_nxt)
      DWR:     w_grant_addr = dWriteMemAddr;
      DRD:     w_grant_addr = dReadMemAddr;
      IRD:     w_grant_addr = iReadMemAddr;
      default: w_grant_addr = r_mem_addr;
    endcase
  end

  // A response is only delivered if its owner still asks for the same line
  always_comb begin
    w_i_pulse = 1'b0;
    w_d_pulse = 1'b0;
    w_wr_ack  = 1'b0;
    if (r_state == RESP) begin
      case (r_owner)
        DWR:     w_wr_ack  = dWriteMemReq && (dWriteMemAddr == r_mem_addr);
        DRD:     w_d_pulse = dReadMemReq && (dReadMemAddr == r_mem_addr);
        IRD:     w_i_pulse = iReadMemReq && (iReadMemAddr == r_mem_addr);
        default: w_wr_ack  = 1'b0;
      endcase
    end else begin
      w_i_pulse = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transaction registers: latched on grant, read data captured on memAck
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner        <= IDLE;
      r_last_grant_d <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_i_data       <= '0;
      r_d_data       <= '0;
    end else if (w_grant) begin
      r_owner    <= w_state_nxt;
      r_mem_req  <= 1'b1;
      r_mem_we   <= (w_state_nxt == DWR);
      r_mem_addr <= w_grant_addr;
      if (w_state_nxt == DWR) begin
        r_mem_wdata <= dWriteMemLine;
      end else begin
        r_last_grant_d <= (w_state_nxt == DRD);
      end
    end else if (w_busy && memAck) begin
      r_mem_req <= 1'b0;
      if (r_state == DRD) begin
        r_d_data <= memRData;
      end else if (r_state == IRD) begin
        r_i_data <= memRData;
      end
    end
  end

  assign memReq            = r_mem_req;
  assign memWE             = r_mem_we;
  assign memAddr           = r_mem_addr;
  assign memWData          = r_mem_wdata;
  assign iReadMemData      = r_i_data;
  assign dReadMemData      = r_d_data;
  assign iReadMemLineValid = w_i_pulse;
  assign dReadMemLineValid = w_d_pulse;
  assign dWriteMemAck      = w_wr_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// a memory responder with programmable latency, and literal pins on grant/pulse order.
module tb_mem_arbiter;
  localparam int AB = 32;
  localparam int LB = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          iReadMemReq, dReadMemReq, dWriteMemReq;
  logic [AB-1:0] iReadMemAddr, dReadMemAddr, dWriteMemAddr;
  logic [LB-1:0] dWriteMemLine, memRData;
  logic [LB-1:0] iReadMemData, dReadMemData, memWData;
  logic          iReadMemLineValid, dReadMemLineValid, dWriteMemAck;
  logic          memReq, memWE, memAck;
  logic [AB-1:0] memAddr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_delay = 3;
  int spur_cnt = 0;

  // observation logs filled from DUT outputs
  logic [AB-1:0] grant_addr_q[$];
  logic          grant_we_q[$];
  int            grant_cyc_q[$];
  int            pulse_q[$];       // 0 = write ack, 1 = dcache fill, 2 = icache fill
  logic [LB-1:0] pulse_data_q[$];
  int            pulse_cyc_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ARCH_BITS(AB), .MEMORY_LINE_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .iReadMemReq(iReadMemReq), .iReadMemAddr(iReadMemAddr),
    .iReadMemData(iReadMemData), .iReadMemLineValid(iReadMemLineValid),
    .dReadMemReq(dReadMemReq), .dReadMemAddr(dReadMemAddr),
    .dReadMemData(dReadMemData), .dReadMemLineValid(dReadMemLineValid),
    .dWriteMemReq(dWriteMemReq), .dWriteMemAddr(dWriteMemAddr),
    .dWriteMemLine(dWriteMemLine), .dWriteMemAck(dWriteMemAck),
    .memReq(memReq), .memWE(memWE), .memAddr(memAddr), .memWData(memWData),
    .memAck(memAck), .memRData(memRData)
  );

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (pulse_q.size() < n && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("wait_pulses", 128'(pulse_q.size() >= n), 128'd1);
  endtask

  task automatic wait_grants(input int n);
    int k = 0;
    while (grant_addr_q.size() < n && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("wait_grants", 128'(grant_addr_q.size() >= n), 128'd1);
  endtask

  task automatic clear_logs();
    grant_addr_q.delete(); grant_we_q.delete(); grant_cyc_q.delete();
    pulse_q.delete(); pulse_data_q.delete(); pulse_cyc_q.delete();
  endtask

  initial begin
    int req_cyc;
    rst = 1'b1;
    iReadMemReq = 1'b0; dReadMemReq = 1'b0; dWriteMemReq = 1'b0;
    iReadMemAddr = '0; dReadMemAddr = '0; dWriteMemAddr = '0;
    dWriteMemLine = '0; memRData = '0; memAck = 1'b0;

    fork
      // memory responder: ack ack_delay cycles after memReq rises, or on a spurious request
      begin
        bit armed = 1'b0;
        int cnt = 0;
        int spur_seen = 0;
        forever begin
          @(posedge clk);
          #1;
          memAck = 1'b0;
          if (armed) begin
            cnt--;
            if (cnt == 0) begin
              memAck = 1'b1;
              armed = 1'b0;
            end
          end else if (memReq) begin
            armed = 1'b1;
            cnt = ack_delay;
          end
          if (spur_cnt != spur_seen) begin
            spur_seen = spur_cnt;
            memAck = 1'b1;
          end
        end
      end
      // transaction model and per-cycle comparison
      begin
        int            m_phase = 0;   // 0 free, 1 memory busy, 2 answering
        int            m_owner = 0;
        logic [AB-1:0] m_addr = '0;
        logic          m_we = 1'b0;
        logic          m_last_d = 1'b0;
        logic [LB-1:0] m_wdata = '0;
        logic [LB-1:0] m_rdata = '0;
        logic          prev_req = 1'b0;
        logic          exp_i, exp_d, exp_w;
        forever begin
          @(negedge clk);
          cyc++;
          if (rst) begin
            chk("rst_memReq", 128'(memReq), 128'd0);
            chk("rst_memWE", 128'(memWE), 128'd0);
            chk("rst_memAddr", 128'(memAddr), 128'd0);
            chk("rst_memWData", memWData, 128'd0);
            chk("rst_iData", iReadMemData, 128'd0);
            chk("rst_dData", dReadMemData, 128'd0);
            chk("rst_pulses", 128'({iReadMemLineValid, dReadMemLineValid, dWriteMemAck}), 128'd0);
            m_phase = 0; m_last_d = 1'b0; prev_req = 1'b0;
          end else begin
            chk("memReq", 128'(memReq), 128'(m_phase == 1));
            if (m_phase == 1) begin
              chk("memAddr", 128'(memAddr), 128'(m_addr));
              chk("memWE", 128'(memWE), 128'(m_we));
              if (m_we) chk("memWData", memWData, m_wdata);
            end
            exp_w = (m_phase == 2) && (m_owner == 0) && dWriteMemReq && (dWriteMemAddr == m_addr);
            exp_d = (m_phase == 2) && (m_owner == 1) && dReadMemReq && (dReadMemAddr == m_addr);
            exp_i = (m_phase == 2) && (m_owner == 2) && iReadMemReq && (iReadMemAddr == m_addr);
            chk("dWriteMemAck", 128'(dWriteMemAck), 128'(exp_w));
            chk("dReadMemLineValid", 128'(dReadMemLineValid), 128'(exp_d));
            chk("iReadMemLineValid", 128'(iReadMemLineValid), 128'(exp_i));
            if (exp_d) chk("dReadMemData", dReadMemData, m_rdata);
            if (exp_i) chk("iReadMemData", iReadMemData, m_rdata);
            if (memReq && !prev_req) begin
              grant_addr_q.push_back(memAddr); grant_we_q.push_back(memWE); grant_cyc_q.push_back(cyc);
            end
            if (dWriteMemAck) begin pulse_q.push_back(0); pulse_data_q.push_back('0); pulse_cyc_q.push_back(cyc); end
            if (dReadMemLineValid) begin pulse_q.push_back(1); pulse_data_q.push_back(dReadMemData); pulse_cyc_q.push_back(cyc); end
            if (iReadMemLineValid) begin pulse_q.push_back(2); pulse_data_q.push_back(iReadMemData); pulse_cyc_q.push_back(cyc); end
            prev_req = memReq;
            if (m_phase == 0) begin
              if (dWriteMemReq) begin
                m_phase = 1; m_owner = 0; m_addr = dWriteMemAddr; m_we = 1'b1; m_wdata = dWriteMemLine;
              end else if (dReadMemReq && (!iReadMemReq || !m_last_d)) begin
                m_phase = 1; m_owner = 1; m_addr = dReadMemAddr; m_we = 1'b0; m_last_d = 1'b1;
              end else if (iReadMemReq) begin
                m_phase = 1; m_owner = 2; m_addr = iReadMemAddr; m_we = 1'b0; m_last_d = 1'b0;
              end
            end else if (m_phase == 1) begin
              if (memAck) begin
                m_phase = 2; m_rdata = memRData;
              end
            end else begin
              m_phase = 0;
            end
          end
        end
      end
    join_none

    step(3);
    rst = 1'b0;
    step(2);

    // single icache miss
    clear_logs();
    memRData = 128'h11112222333344445555666677778888;
    iReadMemReq = 1'b1; iReadMemAddr = 32'h100;
    req_cyc = cyc + 1;
    wait_pulses(1);
    step(1);
    iReadMemReq = 1'b0;
    step(2);
    chk("t1_grant_addr", 128'(grant_addr_q[0]), 128'h100);
    chk("t1_grant_we", 128'(grant_we_q[0]), 128'd0);
    chk("t1_memreq_latency", 128'(grant_cyc_q[0] - req_cyc), 128'd1);
    chk("t1_pulse_latency", 128'(pulse_cyc_q[0] - grant_cyc_q[0]), 128'd4);
    chk("t1_pulse_owner", 128'(pulse_q[0]), 128'd2);
    chk("t1_pulse_data", pulse_data_q[0], 128'h11112222333344445555666677778888);
    chk("t1_pulse_count", 128'(pulse_q.size()), 128'd1);

    // eviction: writeback precedes the fill
    clear_logs();
    memRData = 128'hDEADBEEF0000111122223333CAFEF00D;
    dWriteMemReq = 1'b1; dWriteMemAddr = 32'h240; dWriteMemLine = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    dReadMemReq = 1'b1; dReadMemAddr = 32'h640;
    wait_pulses(1);
    step(1);
    dWriteMemReq = 1'b0;
    wait_pulses(2);
    step(1);
    dReadMemReq = 1'b0;
    step(2);
    chk("t2_first_we", 128'(grant_we_q[0]), 128'd1);
    chk("t2_first_addr", 128'(grant_addr_q[0]), 128'h240);
    chk("t2_second_addr", 128'(grant_addr_q[1]), 128'h640);
    chk("t2_order", 128'({pulse_q[0][1:0], pulse_q[1][1:0]}), 128'h1);
    chk("t2_fill_data", pulse_data_q[1], 128'hDEADBEEF0000111122223333CAFEF00D);

    // round-robin contention from reset
    rst = 1'b1;
    iReadMemReq = 1'b1; iReadMemAddr = 32'h300;
    dReadMemReq = 1'b1; dReadMemAddr = 32'h400;
    step(2);
    clear_logs();
    rst = 1'b0;
    wait_pulses(4);
    step(1);
    iReadMemReq = 1'b0; dReadMemReq = 1'b0;
    step(2);
    chk("t3_order", 128'({pulse_q[0][1:0], pulse_q[1][1:0], pulse_q[2][1:0], pulse_q[3][1:0]}), 128'h66);
    chk("t3_addr0", 128'(grant_addr_q[0]), 128'h400);
    chk("t3_addr1", 128'(grant_addr_q[1]), 128'h300);
    chk("t3_grants", 128'(grant_addr_q.size()), 128'd4);

    // withdrawn icache request, pending dcache read follows
    clear_logs();
    memRData = 128'h0123456789ABCDEF0123456789ABCDEF;
    iReadMemReq = 1'b1; iReadMemAddr = 32'h500;
    step(1);
    dReadMemReq = 1'b1; dReadMemAddr = 32'h600;
    wait_grants(1);
    step(1);
    iReadMemReq = 1'b0;
    wait_pulses(1);
    step(1);
    dReadMemReq = 1'b0;
    step(2);
    chk("t4_first_addr", 128'(grant_addr_q[0]), 128'h500);
    chk("t4_second_addr", 128'(grant_addr_q[1]), 128'h600);
    chk("t4_only_dfill", 128'(pulse_q[0]), 128'd1);
    chk("t4_pulse_count", 128'(pulse_q.size()), 128'd1);

    // reset in the middle of a transaction, late memAck afterwards
    clear_logs();
    ack_delay = 4;
    iReadMemReq = 1'b1; iReadMemAddr = 32'h700;
    wait_grants(1);
    step(2);
    rst = 1'b1; iReadMemReq = 1'b0;
    step(2);
    rst = 1'b0;
    step(4);
    ack_delay = 3;
    chk("t5_no_pulse", 128'(pulse_q.size()), 128'd0);
    chk("t5_idle_memReq", 128'(memReq), 128'd0);

    // spurious memAck while idle
    clear_logs();
    spur_cnt++;
    step(4);
    chk("t6_no_pulse", 128'(pulse_q.size()), 128'd0);
    chk("t6_no_grant", 128'(grant_addr_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
